// File: rtl/radix_mult.sv
// radix_mult: sequential unsigned multiplier, DIGIT_BITS multiplier bits per clock.
// Ports: clk_in/rst_in (sync, active-high); input_1/input_2 operands latched on an
// accepted ready_in; abort_in cancels a run; result held product; busy_out while
// running; valid_out one-cycle pulse when result updates.
module radix_mult #(
  parameter int INPUT_SIZE  = 1024,
  parameter int DIGIT_BITS  = 4,
  parameter int OUTPUT_SIZE = 2*INPUT_SIZE,
  parameter bit EARLY_EXIT  = 1'b1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INPUT_SIZE-1:0]  input_1,
  input  logic [INPUT_SIZE-1:0]  input_2,
  input  logic                   ready_in,
  input  logic                   abort_in,
  output logic [OUTPUT_SIZE-1:0] result,
  output logic                   busy_out,
  output logic                   valid_out
);

  localparam int ND = INPUT_SIZE / DIGIT_BITS;
  localparam int IW = $clog2(ND + 1);
  localparam int PW = INPUT_SIZE + DIGIT_BITS;
  localparam int SW = $clog2(OUTPUT_SIZE);

  generate
    if (DIGIT_BITS < 1 || (INPUT_SIZE % DIGIT_BITS) != 0) begin : g_bad_digit
      $error("radix_mult: DIGIT_BITS must divide INPUT_SIZE");
    end
    if (OUTPUT_SIZE < 2*INPUT_SIZE) begin : g_bad_out
      $error("radix_mult: OUTPUT_SIZE must hold the full product");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INPUT_SIZE-1:0]  a_q, a_d;
  logic [INPUT_SIZE-1:0]  b_q, b_d;
  logic [OUTPUT_SIZE-1:0] acc_q, acc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [OUTPUT_SIZE-1:0] result_d;
  logic                   busy_d;
  logic                   valid_d;

  logic [DIGIT_BITS-1:0]  digit;
  logic [PW-1:0]          pp;
  logic [SW-1:0]          shamt;
  logic [OUTPUT_SIZE-1:0] step;
  logic                   done;

  // One radix-2^DIGIT_BITS partial product, aligned to its digit position.
  // The largest shift is INPUT_SIZE-DIGIT_BITS, which always fits SW bits.
  always_comb begin
    digit = b_q[DIGIT_BITS-1:0];
    pp    = PW'(a_q) * PW'(digit);
    shamt = SW'(idx_q) * SW'(DIGIT_BITS);
    step  = OUTPUT_SIZE'(pp) << shamt;
  end

  // Consumed digits leave b shifted down, so b==0 means nothing left to add.
  always_comb begin
    done = (idx_q == IW'(ND)) || (EARLY_EXIT && (b_q == '0));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result;
    busy_d   = busy_out;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ready_in) begin
          a_d     = input_1;
          b_d     = input_2;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_in) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (done) begin
          result_d = acc_q;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          acc_d = acc_q + step;
          b_d   = b_q >> DIGIT_BITS;
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      result    <= '0;
      busy_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      result    <= result_d;
      busy_out  <= busy_d;
      valid_out <= valid_d;
    end
  end

endmodule
